rc5_sched: RTL and testbench

//  - Shares one rc5_core between two requesters. Two-way round-robin arbitration.
//  - Sequences each job: optional key load (key_en, then wait key_ok), block issue (din_en), capture (dout_en), return.
//  - Key cache: the key load is skipped when the granted requester's key equals the key already loaded in the core.
//  - Sits between the system bus adapters and rc5_core, at the same level as rc5_core inside top.

---
 rtl/rc5_sched_pkg.sv | 12 +
 rtl/rc5_rr_arb2.sv | 21 ++
 rtl/rc5_sched.sv | 141 ++++++++++++++
 tb/tb_rc5_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rc5_sched_pkg.sv
// rc5_sched_pkg: shared widths and FSM state encoding for the rc5 core scheduler
package rc5_sched_pkg;
    localparam int RC5_KEY_W = 128;
    localparam int RC5_BLK_W = 64;
    localparam int N_REQ     = 2;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_KEY       = 3'd1;
    localparam logic [2:0] S_KEY_WAIT  = 3'd2;
    localparam logic [2:0] S_DIN       = 3'd3;
    localparam logic [2:0] S_DOUT_WAIT = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;
endpackage

// File: rtl/rc5_rr_arb2.sv
// rc5_rr_arb2: two-way round-robin grant; combinational grant, registered priority pointer
module rc5_rr_arb2 import rc5_sched_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    input  logic             advance,
    input  logic             done_g,
    output logic             gnt_idx,
    output logic             any_req
);
    logic rr_ptr_q, rr_ptr_d;
    always_comb begin
        rr_ptr_d = advance ? ~done_g : rr_ptr_q;
        any_req  = |req_valid;
        gnt_idx  = (&req_valid) ? rr_ptr_q : req_valid[1];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr_q <= 1'b0;
        else      rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/rc5_sched.sv
// rc5_sched: shares one rc5_core between two requesters with a key cache.
// RC5_SCHED_TIMEOUT_EN adds an abort timer on the key_ok and dout_en waits.
module rc5_sched import rc5_sched_pkg::*; #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*RC5_KEY_W-1:0] req_key,
    input  logic [N_REQ*RC5_BLK_W-1:0] req_din,
    output logic [N_REQ-1:0]           resp_valid,
    input  logic [N_REQ-1:0]           resp_ready,
    output logic [RC5_BLK_W-1:0]       resp_dout,
    output logic                       resp_err,
    output logic [RC5_KEY_W-1:0]       core_key,
    output logic                       core_key_en,
    input  logic                       core_key_ok,
    output logic [RC5_BLK_W-1:0]       core_din,
    output logic                       core_din_en,
    input  logic [RC5_BLK_W-1:0]       core_dout,
    input  logic                       core_dout_en
);
    if (2**CNT_W <= TIMEOUT_CYC) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CYC");
    end
    logic [2:0]           state_q, state_d;
    logic                 g_q, g_d;
    logic [RC5_KEY_W-1:0] key_q, key_d, loaded_q, loaded_d;
    logic [RC5_BLK_W-1:0] din_q, din_d, dout_q, dout_d;
    logic                 key_vld_q, key_vld_d, kw_first_q, kw_first_d;
    logic                 gnt_idx, any_req, take, hit, advance;
    logic [RC5_KEY_W-1:0] sel_key;
    logic [RC5_BLK_W-1:0] sel_din;
`ifdef RC5_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);
    logic             err_q, err_d, waiting;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif
    rc5_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .advance   (advance),
        .done_g    (g_q),
        .gnt_idx   (gnt_idx),
        .any_req   (any_req)
    );
    always_comb begin
        sel_key    = gnt_idx ? req_key[2*RC5_KEY_W-1:RC5_KEY_W] : req_key[RC5_KEY_W-1:0];
        sel_din    = gnt_idx ? req_din[2*RC5_BLK_W-1:RC5_BLK_W] : req_din[RC5_BLK_W-1:0];
        take       = (state_q == S_IDLE) && any_req;
        hit        = key_vld_q && (sel_key == loaded_q);
        advance    = (state_q == S_RESP) && resp_ready[g_q];
        kw_first_d = (state_q == S_KEY);
        state_d    = state_q;
        g_d        = g_q;
        key_d      = key_q;
        din_d      = din_q;
        loaded_d   = loaded_q;
        key_vld_d  = key_vld_q;
        dout_d     = dout_q;
        case (state_q)
            S_IDLE: if (take) begin
                g_d     = gnt_idx;
                key_d   = sel_key;
                din_d   = sel_din;
                state_d = hit ? S_DIN : S_KEY;
            end
            S_KEY:      state_d = S_KEY_WAIT;
            // a key_ok level left over from the previous load must not count
            S_KEY_WAIT: if (core_key_ok && !kw_first_q) begin
                key_vld_d = 1'b1;
                loaded_d  = key_q;
                state_d   = S_DIN;
            end
            S_DIN:       state_d = S_DOUT_WAIT;
            S_DOUT_WAIT: if (core_dout_en) begin
                dout_d  = core_dout;
                state_d = S_RESP;
            end
            S_RESP:  state_d = advance ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
`ifdef RC5_SCHED_TIMEOUT_EN
        waiting = (state_q == S_KEY_WAIT) || (state_q == S_DOUT_WAIT);
        err_d   = advance ? 1'b0 : err_q;
        if (waiting && state_d == state_q && cnt_q + 1'b1 == TO_LIM) begin
            key_vld_d = 1'b0;
            dout_d    = '0;
            err_d     = 1'b1;
            state_d   = S_RESP;
        end
        cnt_d = (waiting && state_d == state_q) ? cnt_q + 1'b1 : '0;
`endif
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            g_q        <= 1'b0;
            key_q      <= '0;
            din_q      <= '0;
            loaded_q   <= '0;
            key_vld_q  <= 1'b0;
            dout_q     <= '0;
            kw_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            key_q      <= key_d;
            din_q      <= din_d;
            loaded_q   <= loaded_d;
            key_vld_q  <= key_vld_d;
            dout_q     <= dout_d;
            kw_first_q <= kw_first_d;
        end
    end
`ifdef RC5_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif
    // req_ready is combinational, so it is gated to stay 0 while reset is held
    assign req_ready   = (take && rst) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    assign resp_valid  = (state_q == S_RESP) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
    assign core_key_en = (state_q == S_KEY);
    assign core_din_en = (state_q == S_DIN);
    assign core_key    = key_q;
    assign core_din    = din_q;
    assign resp_dout   = dout_q;
endmodule

// File: tb/tb_rc5_sched.sv
// tb_rc5_sched: directed plus randomized jobs against a job-level model of the scheduler
module tb_rc5_sched;
    localparam int TO = 15;
    logic         clk = 1'b0, rst = 1'b0;
    logic [1:0]   req_valid = '0, req_ready, resp_valid, resp_ready = '0;
    logic [255:0] req_key = '0;
    logic [127:0] req_din = '0, core_key;
    logic [63:0]  resp_dout, core_din, core_dout = '0;
    logic         resp_err, core_key_en, core_key_ok = 1'b0, core_din_en, core_dout_en = 1'b0;
    int n_cmp = 0, n_bad = 0, ken_cnt = 0, den_cnt = 0;
    logic         m_rr = 1'b0, m_kv = 1'b0;
    logic [127:0] m_key = '0;

    rc5_sched #(.TIMEOUT_CYC(TO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_din(req_din), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_dout(resp_dout), .resp_err(resp_err),
        .core_key(core_key), .core_key_en(core_key_en), .core_key_ok(core_key_ok),
        .core_din(core_din), .core_din_en(core_din_en), .core_dout(core_dout),
        .core_dout_en(core_dout_en)
    );

    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (core_key_en) ken_cnt++;
        if (core_din_en) den_cnt++;
    end

    function automatic void chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [63:0] cipher(input logic [127:0] k, input logic [63:0] d);
        return d ^ k[63:0] ^ k[127:64] ^ 64'h5a5a_0000_ffff_1234;
    endfunction

    // One job from request to acceptance of the response; the bench plays the core.
    task automatic run_job(output int g, input logic [1:0] vm, input logic [127:0] k0, k1,
                           input logic [63:0] d0, d1, input int kd, input bit lvl,
                           input int dd, input int bp, input bit to);
        int i, ke0, de0;
        bit hit;
        logic [127:0] kg;
        logic [63:0] dg, res;
        logic [1:0] vexp;
        g    = (vm == 2'b11) ? int'(m_rr) : (vm[1] ? 1 : 0);
        kg   = g ? k1 : k0;
        dg   = g ? d1 : d0;
        hit  = m_kv && (m_key == kg);
        res  = to ? 64'h0 : cipher(kg, dg);
        vexp = (g == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        req_valid = vm; req_key = {k1, k0}; req_din = {d1, d0};
        resp_ready = 2'b00; core_key_ok = lvl;
        #1;
        chk("resp_valid_idle", resp_valid, 0);
        ke0 = ken_cnt; de0 = den_cnt;
        i = 0;
        while (req_ready == 2'b00 && i < 20) begin
            @(negedge clk); #1; i++;
        end
        chk("grant", req_ready, vexp);
        @(negedge clk); #1;
        chk("req_ready_busy", req_ready, 0);
        chk("key_en", core_key_en, !hit);
        chk("din_en_direct", core_din_en, hit);
        if (!hit) begin
            chk("core_key", core_key, kg);
            for (i = 1; i < 60; i++) begin
                @(negedge clk);
                core_key_ok = lvl || (i == 1 + kd);
                #1;
                if (core_din_en) break;
            end
            chk("key_wait_len", i, lvl ? 3 : 2 + kd);
            core_key_ok = lvl;
        end
        chk("core_din", core_din, dg);
        core_dout_en = 1'b1; core_dout = ~res;
        for (i = 1; i < 60; i++) begin
            @(negedge clk);
            core_dout_en = !to && (i == 1 + dd);
            core_dout = (i == 1 + dd) ? cipher(kg, dg) : 64'($urandom);
            #1;
            if (resp_valid != 2'b00) break;
        end
        chk("dout_latency", i, to ? 1 + TO : 2 + dd);
        chk("resp_valid", resp_valid, vexp);
        chk("resp_dout", resp_dout, res);
        chk("resp_err", resp_err, to);
        for (int j = 0; j < bp; j++) begin
            @(negedge clk);
            core_dout_en = j[0]; core_dout = 64'($urandom);
            resp_ready = j[0] ? ~vexp : 2'b00;
            #1;
            chk("bp_valid", resp_valid, vexp);
            chk("bp_dout", resp_dout, res);
        end
        @(negedge clk);
        core_dout_en = 1'b0; resp_ready = vexp;
        #1;
        chk("resp_hold", resp_valid, vexp);
        chk("key_en_count", ken_cnt - ke0, hit ? 0 : 1);
        chk("din_en_count", den_cnt - de0, 1);
        m_rr = (g == 0);
        m_kv = !to;
        m_key = kg;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0; req_valid = 2'b11; resp_ready = 2'b00; #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_key_en", core_key_en, 0);
        chk("rst_din_en", core_din_en, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_core_din", core_din, 0);
        chk("rst_dout", resp_dout, 0);
        chk("rst_err", resp_err, 0);
        @(negedge clk); req_valid = 2'b00; rst = 1'b1;
        m_kv = 1'b0; m_rr = 1'b0;
    endtask

    initial begin
        int g, g2;
        logic [3:0] gs;
        logic [127:0] K, K2, pool [3];
        K  = 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f;
        K2 = 128'hfedc_ba98_7654_3210_1122_3344_5566_7788;
        pool[0] = K; pool[1] = K2;
        pool[2] = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) @(negedge clk);
        do_reset();
        run_job(g, 2'b01, K, K2, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 1'b0, 1, 3, 1'b0);
        run_job(g, 2'b10, K2, K, 64'h1, 64'hdead_beef_0bad_f00d, 1, 1'b0, 0, 0, 1'b0);
        run_job(g, 2'b10, K, K2, 64'h2, 64'h3333_4444_5555_6666, 1, 1'b1, 2, 0, 1'b0);
        run_job(g, 2'b01, K2, K, 64'h7777_8888_9999_aaaa, 64'h3, 1, 1'b0, 3, 10, 1'b0);
        // reset while the job sits in DOUT_WAIT: nothing delivered, key reloaded next time
        @(negedge clk); resp_ready = 2'b00; req_valid = 2'b01; req_key = {K2, K}; core_key_ok = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); core_key_ok = 1'b1;
        @(negedge clk); core_key_ok = 1'b0; #1;
        chk("rst_job_din_en", core_din_en, 1);
        @(negedge clk); #1;
        do_reset();
        run_job(g, 2'b01, K, K2, 64'h4, 64'h5, 1, 1'b0, 0, 0, 1'b0);
        do_reset();
        gs = '0;
        for (int n = 0; n < 4; n++) begin
            run_job(g, 2'b11, pool[$urandom_range(0, 2)], pool[$urandom_range(0, 2)],
                    64'($urandom), 64'($urandom), $urandom_range(1, 4), 1'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 2), 1'b0);
            gs[n] = g[0];
        end
        chk("contention_order", gs, 4'b1010);
        for (int n = 0; n < 8; n++) begin
            run_job(g, 2'($urandom_range(1, 3)), pool[$urandom_range(0, 2)],
                    pool[$urandom_range(0, 2)], 64'($urandom), 64'($urandom),
                    $urandom_range(1, 5), 1'($urandom), $urandom_range(0, 5),
                    $urandom_range(0, 3), 1'b0);
        end
`ifdef RC5_SCHED_TIMEOUT_EN
        run_job(g, 2'b01, K2, K, 64'h9, 64'h8, 1, 1'b0, 0, 0, 1'b1);
        run_job(g2, 2'b10, K, K2, 64'h6, 64'h7, 2, 1'b0, 1, 0, 1'b0);
`else
        run_job(g2, 2'b10, K, K2, 64'h6, 64'h7, 2, 1'b0, 1, 0, 1'b0);
`endif
        @(negedge clk); resp_ready = 2'b00; req_valid = 2'b00; #1;
        chk("final_idle", resp_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
